bitwise_logic_pipe: RTL



---
 rtl/logic_op_pkg.sv | 33 +++
 rtl/logic_pipe_stage.sv | 33 +++
 rtl/bitwise_logic_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// Shared opcode encoding for the bitwise logic pipe, plus a per-bit reference
// evaluator that the verification model uses.
package logic_op_pkg;

    typedef enum logic [2:0] {
        OP_NAND,
        OP_AND,
        OP_OR,
        OP_NOR,
        OP_XOR,
        OP_XNOR,
        OP_ANDN,
        OP_NOTA
    } logic_op_e;

    function automatic logic logic_eval(input logic_op_e op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_NAND: r = ~(a & b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            OP_NOTA: r = ~a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice; the load enable (this slice's ready) is
// resolved by the parent so the whole ready chain sits in a single comb block.
module logic_pipe_stage #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ready,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // NOTE: sequential state uses <= so every slice samples its upstream
    // neighbour's pre-edge value; = here would let a beat race through stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (ready) begin
            out_valid <= in_valid;
        end
    end

    // NOTE: payload has no reset; it is only observed qualified by out_valid,
    // so leaving it off the reset tree keeps these as plain enable flops.
    always_ff @(posedge clk) begin
        if (ready && in_valid) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Runtime-selectable eight-function bitwise lane array with DEPTH registered,
// back-pressured stages, zero/all-ones flags and a saturating result counter.
module bitwise_logic_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic_op_e        op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int SW = WIDTH + 2;

    logic [WIDTH-1:0] fn_res;
    logic [SW-1:0]    head_data;
    logic             stage_valid [DEPTH];
    logic [SW-1:0]    stage_data  [DEPTH];
    logic [DEPTH:0]   stage_ready;

    // NOTE: every always_comb output gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        fn_res = '0;
        case (op)
            OP_NAND: fn_res = ~(in1 & in2);
            OP_AND:  fn_res = in1 & in2;
            OP_OR:   fn_res = in1 | in2;
            OP_NOR:  fn_res = ~(in1 | in2);
            OP_XOR:  fn_res = in1 ^ in2;
            OP_XNOR: fn_res = ~(in1 ^ in2);
            OP_ANDN: fn_res = in1 & ~in2;
            OP_NOTA: fn_res = ~in1;
            default: fn_res = '0;
        endcase
    end

    assign head_data = {fn_res, ~|fn_res, &fn_res};

    // A slice may load when it is empty or its downstream neighbour is loading.
    always_comb begin
        stage_ready        = '0;
        stage_ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          v_in;
        logic [SW-1:0] d_in;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign d_in = head_data;
        end else begin : g_link
            assign v_in = stage_valid[k-1];
            assign d_in = stage_data[k-1];
        end

        logic_pipe_stage #(.W(SW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .ready     (stage_ready[k]),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (stage_valid[k]),
            .out_data  (stage_data[k])
        );
    end

    assign in_ready                   = stage_ready[0];
    assign out_valid                  = stage_valid[DEPTH-1];
    assign {out, out_zero, out_ones}  = stage_data[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready && (done_cnt != {CNT_W{1'b1}})) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule
